onehot_slot_alloc: RTL and testbench
====================================

Name: onehot_slot_alloc

Overview:
- Parametrised slot allocator built on binary/one-hot index conversion.
- Tracks a busy mask of NUM_SLOTS slots (warp slots, MSHR entries, tag IDs).
- Grants one free slot per cycle through a valid/ready handshake and returns it as both binary index and one-hot mask.
- Accepts one release per cycle by binary index, and reports free count, full/empty state and a sticky error flag.

Parameters:
- NUM_SLOTS, 8, number of slots; any value >= 2, need not be a power of two.
- IDX_WIDTH, $clog2(NUM_SLOTS), binary index width.
- RR_MODE, 0, selects the pick policy: 0 = lowest-index free slot; 1 = round-robin from a rotating pointer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- alloc_valid_o  out  1  at least one slot is free.
- alloc_ready_i  in  1  consumer takes the offered slot this cycle.
- alloc_idx_o  out  IDX_WIDTH  binary index of the offered slot.
- alloc_oh_o  out  NUM_SLOTS  one-hot of the offered slot; all zero when alloc_valid_o=0.
- rel_valid_i  in  1  release request.
- rel_idx_i  in  IDX_WIDTH  binary index of the slot to release.
- busy_o  out  NUM_SLOTS  registered busy mask.
- free_cnt_o  out  IDX_WIDTH+1  registered count of free slots.
- full_o  out  1  no free slot (free_cnt_o==0).
- empty_o  out  1  all slots free (free_cnt_o==NUM_SLOTS).
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - busy=0, free_cnt=NUM_SLOTS, rr_ptr=0, err=0.
  - Resulting outputs: alloc_valid_o=1, alloc_idx_o=0, alloc_oh_o=1, full_o=0, empty_o=1, err_o=0.
  - Reset overrides any same-cycle alloc or release.
- Offer path:
  - Combinational from registered busy and rr_ptr; zero-latency offer.
  - The handshake fires when alloc_valid_o && alloc_ready_i.
  - alloc_ready_i is ignored when alloc_valid_o=0.
- Pick rule, RR_MODE=0: lowest index i with busy[i]=0.
- Pick rule, RR_MODE=1:
  - Picks the first free index scanning rr_ptr, rr_ptr+1, ... modulo NUM_SLOTS.
  - On a fire, rr_ptr <= picked+1; it wraps to 0 when picked==NUM_SLOTS-1.
  - rr_ptr does not change without a fire.
- Fire: busy[idx] <= 1 on the next edge.
- Release:
  - Legal only when rel_idx_i < NUM_SLOTS and busy[rel_idx_i]=1; then busy[rel_idx_i] <= 0.
  - Otherwise the release is dropped: busy is unchanged, count is unchanged, and err <= 1.
  - err stays set until reset.
- Same-cycle alloc fire and legal release:
  - Both apply.
  - The release is evaluated against the pre-edge busy mask, so releasing the slot being offered is illegal (it is free) and sets err.
  - A released slot is offerable from the next cycle, never the same cycle.
- Free count update:
  - free_cnt <= free_cnt - fire + legal_release, computed in IDX_WIDTH+1 bits.
  - Never underflows or overflows, because illegal releases are dropped and fire requires a free slot.
  - Invariant: free_cnt == NUM_SLOTS - popcount(busy).
- Full case:
  - alloc_valid_o=0, alloc_oh_o=0, alloc_idx_o=0.
  - A release in this cycle makes alloc_valid_o=1 on the following cycle.
- Index range: indices >= NUM_SLOTS (non-power-of-two NUM_SLOTS) are never offered, and releasing them is an error.

Decomposition:
- Shared package holds:
  - the clog2 helper;
  - the localparam CNT_WIDTH=IDX_WIDTH+1;
  - the pick-policy constants PICK_LOWEST=0 and PICK_RR=1.
- One natural sub-module: onehot_rr_pick (NUM_SLOTS, RR_MODE).
  - Inputs: free mask and rr_ptr.
  - Outputs: valid, one-hot and binary index.
  - Implementation: rotate, priority-pick, un-rotate; the binary index comes from a one-hot-to-binary OR-tree.
- The top level holds busy, free_cnt, rr_ptr, err and the release decode (binary to one-hot shift gated by rel_valid_i).

Test Plan:
1. Reset, then alloc_ready_i=1 for 4 cycles, NUM_SLOTS=4, RR_MODE=0 -> offered idx 0,1,2,3 and oh 0001,0010,0100,1000; after that full_o=1, alloc_valid_o=0, free_cnt_o=0.
2. From full, release idx 2 -> next cycle alloc_valid_o=1, alloc_idx_o=2, busy_o=1011, free_cnt_o=1; fire -> full again.
3. RR_MODE=1, NUM_SLOTS=4:
   - allocate 0,1,2, release 0, then allocate -> offers 3 (rr_ptr=3);
   - next allocate -> offers 0 after wrap.
4. Same cycle: fire on idx 1 and legal release of busy idx 0 -> busy updates both; free_cnt unchanged; err_o=0.
5. Release of a free slot (idx 3 while busy_o=0001), and release of idx 6 with NUM_SLOTS=6 -> err_o=1 and stays 1; busy and free_cnt unchanged.
6. Assert rst mid-operation with busy_o=0111 and a simultaneous fire/release -> next cycle busy_o=0, free_cnt_o=NUM_SLOTS, empty_o=1, err_o=0, alloc_idx_o=0.

Source files
------------

// File: rtl/onehot_slot_alloc_pkg.sv
// onehot_slot_alloc_pkg: shared pick-policy constants, index-width helper and default counter width
package onehot_slot_alloc_pkg;
    localparam int PICK_LOWEST = 0;
    localparam int PICK_RR = 1;
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
    localparam int DEF_NUM_SLOTS = 8;
    localparam int CNT_WIDTH = clog2(DEF_NUM_SLOTS) + 1;
endpackage

// File: rtl/onehot_rr_pick.sv
// onehot_rr_pick: picks one free slot, lowest-index or round-robin from a pointer
//   free_i  : mask of free slots
//   ptr_i   : round-robin start index (ignored when RR_MODE is PICK_LOWEST)
//   valid_o : at least one slot is free
//   oh_o    : one-hot of the picked slot, zero when none is free
//   idx_o   : binary index of the picked slot, zero when none is free
module onehot_rr_pick import onehot_slot_alloc_pkg::*; #(
    parameter int NUM_SLOTS = 8,
    parameter int RR_MODE = PICK_LOWEST,
    parameter int IDX_WIDTH = clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] free_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 valid_o,
    output logic [NUM_SLOTS-1:0] oh_o,
    output logic [IDX_WIDTH-1:0] idx_o
);
    logic [IDX_WIDTH-1:0]   sh;
    logic [2*NUM_SLOTS-1:0] dbl_free, dbl_pick;
    logic [NUM_SLOTS-1:0]   rot, pick;
    int                     base;
    always_comb begin
        sh = (RR_MODE == PICK_RR) ? ptr_i : '0;
        // Doubling the mask makes the modulo-NUM_SLOTS rotation a plain window select
        dbl_free = {free_i, free_i};
        rot = dbl_free[sh +: NUM_SLOTS];
        pick = rot & (~rot + NUM_SLOTS'(1));
        dbl_pick = {pick, pick};
        base = NUM_SLOTS - int'(sh);
        oh_o = dbl_pick[base +: NUM_SLOTS];
        valid_o = |free_i;
        idx_o = '0;
        for (int i = 0; i < NUM_SLOTS; i++) idx_o = idx_o | (oh_o[i] ? IDX_WIDTH'(i) : '0);
    end
endmodule

// File: rtl/onehot_slot_alloc.sv
// onehot_slot_alloc: busy-mask slot allocator with valid/ready grant and indexed release
//   alloc_valid_o/alloc_ready_i : grant handshake, fires when both high
//   alloc_idx_o/alloc_oh_o      : offered slot as binary index and one-hot
//   rel_valid_i/rel_idx_i       : release of a busy slot by binary index
//   busy_o, free_cnt_o          : registered busy mask and free count
//   full_o, empty_o             : no slot free / all slots free
//   err_o                       : sticky flag for dropped (illegal) releases
module onehot_slot_alloc import onehot_slot_alloc_pkg::*; #(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_WIDTH = clog2(NUM_SLOTS),
    parameter int RR_MODE = PICK_LOWEST
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 alloc_valid_o,
    input  logic                 alloc_ready_i,
    output logic [IDX_WIDTH-1:0] alloc_idx_o,
    output logic [NUM_SLOTS-1:0] alloc_oh_o,
    input  logic                 rel_valid_i,
    input  logic [IDX_WIDTH-1:0] rel_idx_i,
    output logic [NUM_SLOTS-1:0] busy_o,
    output logic [IDX_WIDTH:0]   free_cnt_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);
    localparam int CNT_W = IDX_WIDTH + 1;
    logic [NUM_SLOTS-1:0] busy_q, busy_d, rel_oh;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0] rr_q, rr_d;
    logic                 err_q, err_d, fire, rel_ok;
    onehot_rr_pick #(
        .NUM_SLOTS(NUM_SLOTS),
        .RR_MODE(RR_MODE),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_pick (
        .free_i(~busy_q),
        .ptr_i(rr_q),
        .valid_o(alloc_valid_o),
        .oh_o(alloc_oh_o),
        .idx_o(alloc_idx_o)
    );
    always_comb begin
        fire = alloc_valid_o & alloc_ready_i;
        // Out-of-range indices shift the bit out of the mask, so they never match busy
        rel_oh = rel_valid_i ? (NUM_SLOTS'(1) << rel_idx_i) : '0;
        rel_ok = |(rel_oh & busy_q);
        busy_d = (busy_q | (fire ? alloc_oh_o : '0)) & ~(rel_ok ? rel_oh : '0);
        cnt_d = cnt_q - CNT_W'(fire) + CNT_W'(rel_ok);
        rr_d = !fire ? rr_q : (alloc_idx_o == IDX_WIDTH'(NUM_SLOTS - 1)) ? '0 : alloc_idx_o + 1'b1;
        err_d = err_q | (rel_valid_i & ~rel_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q <= CNT_W'(NUM_SLOTS);
            rr_q <= '0;
            err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q <= cnt_d;
            rr_q <= rr_d;
            err_q <= err_d;
        end
    end
    assign busy_o = busy_q;
    assign free_cnt_o = cnt_q;
    assign full_o = (cnt_q == '0);
    assign empty_o = (cnt_q == CNT_W'(NUM_SLOTS));
    assign err_o = err_q;
endmodule

// File: tb/tb_onehot_slot_alloc.sv
// tb_onehot_slot_alloc: directed vector table plus round-robin and non-power-of-two sequences
module tb_onehot_slot_alloc;
    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic [3:0] oh;
        logic [3:0] busy;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } out_t;
    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       rv;
        logic [1:0] ridx;
        out_t       o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;

    logic a_rst = 1'b1, a_rdy = 1'b0, a_rv = 1'b0;
    logic [1:0] a_ridx = '0, a_idx;
    logic a_valid, a_full, a_empty, a_err;
    logic [3:0] a_oh, a_busy;
    logic [2:0] a_cnt;
    out_t act_a;
    assign act_a = {a_valid, a_idx, a_oh, a_busy, a_cnt, a_full, a_empty, a_err};
    onehot_slot_alloc #(.NUM_SLOTS(4), .IDX_WIDTH(2), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(a_rst), .alloc_valid_o(a_valid), .alloc_ready_i(a_rdy),
        .alloc_idx_o(a_idx), .alloc_oh_o(a_oh), .rel_valid_i(a_rv), .rel_idx_i(a_ridx),
        .busy_o(a_busy), .free_cnt_o(a_cnt), .full_o(a_full), .empty_o(a_empty), .err_o(a_err)
    );

    logic b_rst = 1'b1, b_rdy = 1'b0, b_rv = 1'b0;
    logic [1:0] b_ridx = '0, b_idx;
    logic b_valid, b_full, b_empty, b_err;
    logic [3:0] b_oh, b_busy;
    logic [2:0] b_cnt;
    onehot_slot_alloc #(.NUM_SLOTS(4), .IDX_WIDTH(2), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(b_rst), .alloc_valid_o(b_valid), .alloc_ready_i(b_rdy),
        .alloc_idx_o(b_idx), .alloc_oh_o(b_oh), .rel_valid_i(b_rv), .rel_idx_i(b_ridx),
        .busy_o(b_busy), .free_cnt_o(b_cnt), .full_o(b_full), .empty_o(b_empty), .err_o(b_err)
    );

    logic c_rst = 1'b1, c_rdy = 1'b0, c_rv = 1'b0;
    logic [2:0] c_ridx = '0, c_idx;
    logic c_valid, c_full, c_empty, c_err;
    logic [5:0] c_oh, c_busy;
    logic [3:0] c_cnt;
    onehot_slot_alloc #(.NUM_SLOTS(6), .IDX_WIDTH(3), .RR_MODE(0)) dut_c (
        .clk(clk), .rst(c_rst), .alloc_valid_o(c_valid), .alloc_ready_i(c_rdy),
        .alloc_idx_o(c_idx), .alloc_oh_o(c_oh), .rel_valid_i(c_rv), .rel_idx_i(c_ridx),
        .busy_o(c_busy), .free_cnt_o(c_cnt), .full_o(c_full), .empty_o(c_empty), .err_o(c_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int rst, rdy, rv, ridx, v, idx, oh, busy, cnt, f, e, er);
        vec_t t;
        t.rst = 1'(rst); t.rdy = 1'(rdy); t.rv = 1'(rv); t.ridx = 2'(ridx);
        t.o.v = 1'(v); t.o.idx = 2'(idx); t.o.oh = 4'(oh); t.o.busy = 4'(busy);
        t.o.cnt = 3'(cnt); t.o.full = 1'(f); t.o.empty = 1'(e); t.o.err = 1'(er);
        return t;
    endfunction

    vec_t tv[17];

    initial begin
        //          rst rdy rv ridx | v idx oh      busy    cnt f e err
        tv[0]  = mk(0, 1, 0, 0, 1, 0, 'b0001, 'b0000, 4, 0, 1, 0);
        tv[1]  = mk(0, 1, 0, 0, 1, 1, 'b0010, 'b0001, 3, 0, 0, 0);
        tv[2]  = mk(0, 1, 0, 0, 1, 2, 'b0100, 'b0011, 2, 0, 0, 0);
        tv[3]  = mk(0, 1, 0, 0, 1, 3, 'b1000, 'b0111, 1, 0, 0, 0);
        tv[4]  = mk(0, 1, 1, 2, 0, 0, 'b0000, 'b1111, 0, 1, 0, 0);
        tv[5]  = mk(0, 1, 0, 0, 1, 2, 'b0100, 'b1011, 1, 0, 0, 0);
        tv[6]  = mk(0, 0, 1, 0, 0, 0, 'b0000, 'b1111, 0, 1, 0, 0);
        tv[7]  = mk(0, 1, 1, 1, 1, 0, 'b0001, 'b1110, 1, 0, 0, 0);
        tv[8]  = mk(0, 1, 1, 0, 1, 1, 'b0010, 'b1101, 1, 0, 0, 0);
        tv[9]  = mk(0, 0, 1, 0, 1, 0, 'b0001, 'b1110, 1, 0, 0, 0);
        tv[10] = mk(0, 1, 1, 1, 1, 0, 'b0001, 'b1110, 1, 0, 0, 1);
        tv[11] = mk(1, 1, 1, 0, 1, 1, 'b0010, 'b1101, 1, 0, 0, 1);
        tv[12] = mk(0, 1, 0, 0, 1, 0, 'b0001, 'b0000, 4, 0, 1, 0);
        tv[13] = mk(0, 1, 0, 0, 1, 1, 'b0010, 'b0001, 3, 0, 0, 0);
        tv[14] = mk(0, 1, 0, 0, 1, 2, 'b0100, 'b0011, 2, 0, 0, 0);
        tv[15] = mk(1, 1, 1, 0, 1, 3, 'b1000, 'b0111, 1, 0, 0, 0);
        tv[16] = mk(0, 0, 0, 0, 1, 0, 'b0001, 'b0000, 4, 0, 1, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            a_rst = tv[i].rst; a_rdy = tv[i].rdy; a_rv = tv[i].rv; a_ridx = tv[i].ridx;
            #3;
            chk($sformatf("vecA%0d", i), 32'(act_a), 32'(tv[i].o));
            tick();
        end
        a_rst = 1'b0; a_rdy = 1'b0; a_rv = 1'b0;

        b_rst = 1'b0; b_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("rr_idx%0d", k), 32'(b_idx), k);
            tick();
        end
        b_rdy = 1'b0; b_rv = 1'b1; b_ridx = 2'd0;
        #3;
        chk("rr_busy_0111", 32'(b_busy), 32'b0111);
        tick();
        b_rv = 1'b0;
        #3;
        chk("rr_busy_0110", 32'(b_busy), 32'b0110);
        chk("rr_ptr_offer3", 32'(b_idx), 3);
        b_rdy = 1'b1;
        tick();
        #3;
        chk("rr_wrap_idx0", 32'(b_idx), 0);
        chk("rr_wrap_oh", 32'(b_oh), 32'b0001);
        tick();
        b_rdy = 1'b0;
        #3;
        chk("rr_full", 32'({b_full, b_valid, b_busy, b_cnt}), 32'({1'b1, 1'b0, 4'b1111, 3'd0}));

        c_rst = 1'b0; c_rv = 1'b1; c_ridx = 3'd6;
        #3;
        chk("n6_reset", 32'({c_valid, c_idx, c_oh, c_busy, c_cnt, c_empty, c_err}),
            32'({1'b1, 3'd0, 6'b000001, 6'b0, 4'd6, 1'b1, 1'b0}));
        tick();
        c_rv = 1'b1; c_ridx = 3'd3;
        #3;
        chk("n6_rel6_err", 32'({c_busy, c_cnt, c_err}), 32'({6'b0, 4'd6, 1'b1}));
        tick();
        c_rv = 1'b0; c_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #3;
            chk($sformatf("n6_alloc%0d", k), 32'({c_idx, c_oh, c_err}), 32'({3'(k), 6'(1 << k), 1'b1}));
            tick();
        end
        c_rv = 1'b1; c_ridx = 3'd7;
        #3;
        chk("n6_full", 32'({c_valid, c_idx, c_oh, c_full, c_cnt}), 32'({1'b0, 3'd0, 6'b0, 1'b1, 4'd0}));
        tick();
        c_rv = 1'b0; c_rdy = 1'b0;
        #3;
        chk("n6_rel7_drop", 32'({c_busy, c_cnt, c_err}), 32'({6'b111111, 4'd0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
